// File: rtl/regfile_2w2r_sb_pkg.sv
// Shared constants and helpers for the two-write/two-read register file
// and its busy scoreboard.
package regfile_2w2r_sb_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic {
    WPORT_W0 = 1'b0,
    WPORT_W1 = 1'b1
  } wport_e;

  // W1 carries the long-latency result the scoreboard waits on, so it wins.
  localparam wport_e WR_PRIO = WPORT_W1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by a reservation, cleared by a W1 writeback,
// with set winning when both target the same register in one cycle.
module regfile_scoreboard
  import regfile_2w2r_sb_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit ZERO_REG0 = 1'b0,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              ra_busy,
  output logic              rb_busy,
  output logic              any_busy
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
    if (ZERO_REG0) busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign ra_busy  = busy[ra_addr];
  assign rb_busy  = busy[rb_addr];
  assign any_busy = |busy;

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Register file with two synchronous write ports, two combinational read
// ports, optional write-to-read bypass, optional zero register and a busy scoreboard.
module regfile_2w2r_sb
  import regfile_2w2r_sb_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit ZERO_REG0 = 1'b0,
  parameter bit BYPASS    = 1'b1,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              w0_en,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [WIDTH-1:0]  w0_data,
  input  logic              w1_en,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [WIDTH-1:0]  w1_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  ra_data,
  output logic [WIDTH-1:0]  rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  output logic              any_busy,
  output logic              wr_conflict
);

  localparam bit W1_WINS = (WR_PRIO == WPORT_W1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w0_act;
  logic             w1_act;
  logic             rsv_act;

  // With a zero register, any access to address 0 is dropped at the source.
  assign w0_act  = w0_en  && !(ZERO_REG0 && (w0_addr  == '0));
  assign w1_act  = w1_en  && !(ZERO_REG0 && (w1_addr  == '0));
  assign rsv_act = rsv_en && !(ZERO_REG0 && (rsv_addr == '0));

  // NOTE: the storage array sits on the async reset because every register must read 0 after reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w1_act && (w1_addr == ADDR_W'(i)) &&
            (W1_WINS || !(w0_act && (w0_addr == ADDR_W'(i))))) begin
          mem[i] <= w1_data;
        end else if (w0_act && (w0_addr == ADDR_W'(i))) begin
          mem[i] <= w0_data;
        end
      end
      wr_conflict <= w0_act && w1_act && (w0_addr == w1_addr);
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [WIDTH-1:0] data;
    // The higher-priority port is applied last so it overrides a double hit.
    always_comb begin
      data = mem[rd_addr[p]];
      if (BYPASS) begin
        if (W1_WINS) begin
          if (w0_act && (w0_addr == rd_addr[p])) data = w0_data;
          if (w1_act && (w1_addr == rd_addr[p])) data = w1_data;
        end else begin
          if (w1_act && (w1_addr == rd_addr[p])) data = w1_data;
          if (w0_act && (w0_addr == rd_addr[p])) data = w0_data;
        end
      end
      if (ZERO_REG0 && (rd_addr[p] == '0)) data = '0;
    end
  end

  assign ra_data = g_rd[0].data;
  assign rb_data = g_rd[1].data;

  regfile_scoreboard #(
    .DEPTH     (DEPTH),
    .ZERO_REG0 (ZERO_REG0)
  ) u_scoreboard (
    .clk      (clk),
    .arst_n   (arst_n),
    .rsv_en   (rsv_act),
    .rsv_addr (rsv_addr),
    .clr_en   (w1_act),
    .clr_addr (w1_addr),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_busy  (ra_busy),
    .rb_busy  (rb_busy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Self-checking bench: three configurations (bypass, no bypass, zero register)
// driven in parallel, checked by a directed table, corner sequences and a random run.
module tb_regfile_2w2r_sb;

  logic       clk;
  logic       arst_n;
  logic       w0_en;
  logic [3:0] w0_addr;
  logic [7:0] w0_data;
  logic       w1_en;
  logic [3:0] w1_addr;
  logic [7:0] w1_data;
  logic       rsv_en;
  logic [3:0] rsv_addr;
  logic [3:0] ra_addr;
  logic [3:0] rb_addr;

  logic [2:0][7:0] ra_d;
  logic [2:0][7:0] rb_d;
  logic [2:0]      rab;
  logic [2:0]      rbb;
  logic [2:0]      anyb;
  logic [2:0]      conf;

  int checks;
  int errors;

  // Variant 0: bypass, 1: no bypass, 2: bypass + zero register.
  bit         bypass_v [3];
  bit         zero_v   [3];
  logic [7:0] mm       [3][16];
  bit         mb       [3][16];
  bit         mc       [3];

  regfile_2w2r_sb #(.ZERO_REG0(1'b0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .arst_n(arst_n),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[0]), .rb_data(rb_d[0]),
    .ra_busy(rab[0]), .rb_busy(rbb[0]), .any_busy(anyb[0]),
    .wr_conflict(conf[0])
  );

  regfile_2w2r_sb #(.ZERO_REG0(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .arst_n(arst_n),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[1]), .rb_data(rb_d[1]),
    .ra_busy(rab[1]), .rb_busy(rbb[1]), .any_busy(anyb[1]),
    .wr_conflict(conf[1])
  );

  regfile_2w2r_sb #(.ZERO_REG0(1'b1), .BYPASS(1'b1)) dut_z (
    .clk(clk), .arst_n(arst_n),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[2]), .rb_data(rb_d[2]),
    .ra_busy(rab[2]), .rb_busy(rbb[2]), .any_busy(anyb[2]),
    .wr_conflict(conf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w0_en;
    logic [3:0] w0_addr;
    logic [7:0] w0_data;
    logic       w1_en;
    logic [3:0] w1_addr;
    logic [7:0] w1_data;
    logic       rsv_en;
    logic [3:0] rsv_addr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] exp_ra;
    logic [7:0] exp_rb;
    logic       exp_ra_busy;
    logic       exp_rb_busy;
    logic       exp_any;
    logic       exp_conf;
  } vec_t;

  function automatic vec_t mk(
    input logic e0, input logic [3:0] a0, input logic [7:0] d0,
    input logic e1, input logic [3:0] a1, input logic [7:0] d1,
    input logic er, input logic [3:0] ar,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [7:0] xra, input logic [7:0] xrb,
    input logic xrab, input logic xrbb, input logic xany, input logic xconf);
    vec_t v;
    v.w0_en = e0; v.w0_addr = a0; v.w0_data = d0;
    v.w1_en = e1; v.w1_addr = a1; v.w1_data = d1;
    v.rsv_en = er; v.rsv_addr = ar;
    v.ra = ra; v.rb = rb;
    v.exp_ra = xra; v.exp_rb = xrb;
    v.exp_ra_busy = xrab; v.exp_rb_busy = xrbb;
    v.exp_any = xany; v.exp_conf = xconf;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    w0_en = v.w0_en; w0_addr = v.w0_addr; w0_data = v.w0_data;
    w1_en = v.w1_en; w1_addr = v.w1_addr; w1_data = v.w1_data;
    rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
    ra_addr = v.ra; rb_addr = v.rb;
  endtask

  task automatic drive_idle(input logic [3:0] ra, input logic [3:0] rb);
    w0_en = 1'b0; w1_en = 1'b0; rsv_en = 1'b0;
    w0_addr = 4'd0; w1_addr = 4'd0; rsv_addr = 4'd0;
    w0_data = 8'h00; w1_data = 8'h00;
    ra_addr = ra; rb_addr = rb;
  endtask

  task automatic model_reset();
    for (int v = 0; v < 3; v++) begin
      for (int r = 0; r < 16; r++) begin
        mm[v][r] = 8'h00;
        mb[v][r] = 1'b0;
      end
      mc[v] = 1'b0;
    end
  endtask

  function automatic logic [7:0] exp_read(input int v, input logic [3:0] addr);
    if (zero_v[v] && addr == 4'd0) return 8'h00;
    if (bypass_v[v]) begin
      if (w1_en && w1_addr == addr) return w1_data;
      if (w0_en && w0_addr == addr) return w0_data;
    end
    return mm[v][addr];
  endfunction

  // Architectural effect of one clock edge: writes land in order with W1 last,
  // completions clear before new reservations set.
  task automatic model_update();
    for (int v = 0; v < 3; v++) begin
      bit e0, e1, er;
      e0 = w0_en  && !(zero_v[v] && w0_addr  == 4'd0);
      e1 = w1_en  && !(zero_v[v] && w1_addr  == 4'd0);
      er = rsv_en && !(zero_v[v] && rsv_addr == 4'd0);
      mc[v] = e0 && e1 && (w0_addr == w1_addr);
      if (e0) mm[v][w0_addr] = w0_data;
      if (e1) mm[v][w1_addr] = w1_data;
      if (e1) mb[v][w1_addr] = 1'b0;
      if (er) mb[v][rsv_addr] = 1'b1;
    end
  endtask

  task automatic check_model();
    for (int v = 0; v < 3; v++) begin
      bit any;
      any = 1'b0;
      for (int r = 0; r < 16; r++) any = any | mb[v][r];
      check($sformatf("v%0d ra_data", v), ra_d[v], exp_read(v, ra_addr));
      check($sformatf("v%0d rb_data", v), rb_d[v], exp_read(v, rb_addr));
      check($sformatf("v%0d ra_busy", v), 8'(rab[v]), 8'(mb[v][ra_addr]));
      check($sformatf("v%0d rb_busy", v), 8'(rbb[v]), 8'(mb[v][rb_addr]));
      check($sformatf("v%0d any_busy", v), 8'(anyb[v]), 8'(any));
      check($sformatf("v%0d wr_conflict", v), 8'(conf[v]), 8'(mc[v]));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    checks = 0;
    errors = 0;
    bypass_v[0] = 1'b1; zero_v[0] = 1'b0;
    bypass_v[1] = 1'b0; zero_v[1] = 1'b0;
    bypass_v[2] = 1'b1; zero_v[2] = 1'b1;

    //           w0                 w1                 rsv       ra     rb     exp_ra exp_rb rab rbb any conf
    vecs[0] = mk(1, 4'd2, 8'h11,    1, 4'd5, 8'h22,    0, 4'd0,  4'd2, 4'd5,  8'h11, 8'h22, 0, 0, 0, 0);
    vecs[1] = mk(0, 4'd0, 8'h00,    0, 4'd0, 8'h00,    0, 4'd0,  4'd2, 4'd5,  8'h11, 8'h22, 0, 0, 0, 0);
    vecs[2] = mk(1, 4'd7, 8'h33,    1, 4'd7, 8'h44,    0, 4'd0,  4'd7, 4'd7,  8'h44, 8'h44, 0, 0, 0, 0);
    vecs[3] = mk(0, 4'd0, 8'h00,    0, 4'd0, 8'h00,    0, 4'd0,  4'd7, 4'd2,  8'h44, 8'h11, 0, 0, 0, 1);
    vecs[4] = mk(0, 4'd0, 8'h00,    0, 4'd0, 8'h00,    0, 4'd0,  4'd7, 4'd5,  8'h44, 8'h22, 0, 0, 0, 0);
    vecs[5] = mk(0, 4'd0, 8'h00,    0, 4'd0, 8'h00,    1, 4'd9,  4'd9, 4'd4,  8'h00, 8'h00, 0, 0, 0, 0);
    vecs[6] = mk(1, 4'd4, 8'h5A,    0, 4'd0, 8'h00,    0, 4'd0,  4'd4, 4'd9,  8'h5A, 8'h00, 0, 1, 1, 0);
    vecs[7] = mk(0, 4'd0, 8'h00,    1, 4'd9, 8'h77,    1, 4'd9,  4'd9, 4'd4,  8'h77, 8'h5A, 1, 0, 1, 0);
    vecs[8] = mk(0, 4'd0, 8'h00,    1, 4'd9, 8'h77,    0, 4'd0,  4'd9, 4'd4,  8'h77, 8'h5A, 1, 0, 1, 0);
    vecs[9] = mk(0, 4'd0, 8'h00,    0, 4'd0, 8'h00,    0, 4'd0,  4'd9, 4'd4,  8'h77, 8'h5A, 0, 0, 0, 0);

    drive_idle(4'd0, 4'd0);
    arst_n = 1'b0;
    model_reset();
    #1;
    check("reset ra_data", ra_d[0], 8'h00);
    check("reset any_busy", 8'(anyb[0]), 8'h00);
    check("reset wr_conflict", 8'(conf[0]), 8'h00);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table against configuration 0, model checks all three.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("tbl%0d ra_data", i), ra_d[0], vecs[i].exp_ra);
      check($sformatf("tbl%0d rb_data", i), rb_d[0], vecs[i].exp_rb);
      check($sformatf("tbl%0d ra_busy", i), 8'(rab[0]), 8'(vecs[i].exp_ra_busy));
      check($sformatf("tbl%0d rb_busy", i), 8'(rbb[0]), 8'(vecs[i].exp_rb_busy));
      check($sformatf("tbl%0d any_busy", i), 8'(anyb[0]), 8'(vecs[i].exp_any));
      check($sformatf("tbl%0d wr_conflict", i), 8'(conf[0]), 8'(vecs[i].exp_conf));
      check_model();
      advance();
    end

    // Bypass vs no bypass: r4 holds 0x5A, a new write of 0xC3 is in flight.
    drive_idle(4'd4, 4'd4);
    w0_en = 1'b1; w0_addr = 4'd4; w0_data = 8'hC3;
    settle();
    check("bypass on before edge", ra_d[0], 8'hC3);
    check("bypass off before edge", ra_d[1], 8'h5A);
    advance();
    drive_idle(4'd4, 4'd4);
    settle();
    check("bypass off after edge", ra_d[1], 8'hC3);
    advance();

    // Zero register: writes and reservation to r0 from both ports.
    drive_idle(4'd0, 4'd0);
    w0_en = 1'b1; w0_addr = 4'd0; w0_data = 8'hFF;
    w1_en = 1'b1; w1_addr = 4'd0; w1_data = 8'hEE;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    settle();
    check("zero reg no bypass", ra_d[2], 8'h00);
    check("r0 bypass w1 wins", ra_d[0], 8'hEE);
    advance();
    drive_idle(4'd0, 4'd0);
    settle();
    check("zero reg data", ra_d[2], 8'h00);
    check("zero reg busy", 8'(rab[2]), 8'h00);
    check("zero reg any_busy", 8'(anyb[2]), 8'h00);
    check("zero reg no conflict", 8'(conf[2]), 8'h00);
    check("r0 conflict normal", 8'(conf[0]), 8'h01);
    check("r0 busy normal", 8'(rab[0]), 8'h01);
    advance();

    // Asynchronous reset mid-operation, with conflict and busy both set.
    drive_idle(4'd3, 4'd3);
    w0_en = 1'b1; w0_addr = 4'd3; w0_data = 8'hA5;
    w1_en = 1'b1; w1_addr = 4'd3; w1_data = 8'hA5;
    rsv_en = 1'b1; rsv_addr = 4'd3;
    settle();
    advance();
    drive_idle(4'd3, 4'd3);
    settle();
    #1;
    arst_n = 1'b0;
    #1;
    model_reset();
    check("async rst ra_data", ra_d[0], 8'h00);
    check("async rst ra_busy", 8'(rab[0]), 8'h00);
    check("async rst any_busy", 8'(anyb[0]), 8'h00);
    check("async rst wr_conflict", 8'(conf[0]), 8'h00);
    w0_en = 1'b1; w0_addr = 4'd3; w0_data = 8'h55;
    @(posedge clk);
    #1;
    w0_en = 1'b0;
    #1;
    check("write held in reset", ra_d[0], 8'h00);
    check("write held in reset nb", ra_d[1], 8'h00);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic with address bias toward collisions and rare resets.
    for (int n = 0; n < 2000; n++) begin
      w0_en    = 1'($urandom_range(0, 1));
      w1_en    = 1'($urandom_range(0, 3) == 0);
      rsv_en   = 1'($urandom_range(0, 3) == 0);
      w0_addr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      w1_addr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      rsv_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ra_addr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      rb_addr  = 4'($urandom);
      w0_data  = 8'($urandom);
      w1_data  = 8'($urandom);
      settle();
      if ($urandom_range(0, 199) == 0) begin
        w0_en = 1'b0; w1_en = 1'b0; rsv_en = 1'b0;
        arst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        #1;
        arst_n = 1'b1;
      end
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Parametrised general-purpose register file for the next-generation 8-bit microcontroller datapath.
- Two combinational read ports serve the ALU operands A and B.
- Two synchronous write ports:
  - W0: ALU writeback.
  - W1: memory/multi-cycle writeback.
- Adds three features:
  - optional write-to-read bypass;
  - optional hard-wired zero register;
  - per-register busy scoreboard, so the decoder can stall on pending multi-cycle results.

Parameters:
- WIDTH, 8, data bits per register.
- DEPTH, 16, number of registers; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_REG0, 0, when 1 register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read data.

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  asynchronous active-low reset.
- w0_en  in  1  ALU write enable.
- w0_addr  in  ADDR_W  ALU write address.
- w0_data  in  WIDTH  ALU write data.
- w1_en  in  1  memory/multi-cycle write enable; also clears busy.
- w1_addr  in  ADDR_W  memory write address.
- w1_data  in  WIDTH  memory write data.
- rsv_en  in  1  reserve: mark rsv_addr busy (multi-cycle op issued).
- rsv_addr  in  ADDR_W  register to reserve.
- ra_addr  in  ADDR_W  read port A address.
- rb_addr  in  ADDR_W  read port B address.
- ra_data  out  WIDTH  read port A data.
- rb_data  out  WIDTH  read port B data.
- ra_busy  out  1  busy bit of ra_addr.
- rb_busy  out  1  busy bit of rb_addr.
- any_busy  out  1  OR of all busy bits.
- wr_conflict  out  1  registered pulse: previous cycle had w0 and w1 writing the same address.

Behaviour:
- Reset (arst_n low, asynchronous):
  - all registers = 0;
  - all busy bits = 0;
  - wr_conflict = 0.
  - Outputs then read 0 and not busy.
  - Reset asserted mid-operation discards any pending writes and reservations immediately.
  - Reset deassertion is assumed synchronised upstream.
- Writes update on the rising edge of clk.
  - Both ports may write different addresses in the same cycle; both take effect.
  - Same address, both enabled: W1 wins. W1 carries the long-latency result the scoreboard waits on. wr_conflict = 1 for exactly the following cycle.
- Reads are combinational: 0-cycle latency from address to data.
  - BYPASS=1, pending write hits the read address this cycle: read data = write data. W1 has priority over W0, matching write priority.
  - BYPASS=0: read data shows the register contents; a write becomes visible the cycle after the edge.
- ZERO_REG0=1:
  - address 0 reads 0 on both ports, with no bypass;
  - writes to 0 are dropped and do not raise wr_conflict;
  - rsv to 0 is ignored; busy[0] is constant 0.
- Scoreboard, one busy bit per register, updated on the clock edge:
  - rsv_en sets busy[rsv_addr].
  - w1_en clears busy[w1_addr].
  - rsv_en and w1_en on the same address in the same cycle: busy ends at 1 (set wins). A new op was issued behind the completing one.
  - w0 writes never change busy. The decoder must not issue an ALU write to a busy register; this is not checked in RTL.
  - rsv on an already busy register leaves it at 1.
  - w1 to a non-busy register writes data normally; busy stays 0.
- ra_busy/rb_busy/any_busy are combinational from the current busy vector. No bypass of same-cycle rsv/clear: visible next cycle.
- Address widths are exact; no out-of-range addresses exist.

Decomposition:
- Shared package/include:
  - default WIDTH/DEPTH constants;
  - ADDR_W derivation helper (clog2 function);
  - write-port priority constant (W1 over W0).
- One natural sub-module, regfile_scoreboard: busy vector, set/clear priority, any_busy and the two busy lookups.
- Storage, bypass muxes and the conflict flag stay in the top.

Test Plan:
- Reset: write 0xA5 to r3, pulse arst_n low -> ra_data at r3 = 0x00, ra_busy = 0, any_busy = 0, wr_conflict = 0, all without a clock edge.
- Dual write, different addresses: w0 r2=0x11 and w1 r5=0x22 in the same cycle -> next cycle r2 = 0x11, r5 = 0x22, wr_conflict = 0.
- Dual write, same address: w0 r7=0x33 and w1 r7=0x44 -> r7 = 0x44, wr_conflict = 1 for one cycle, then 0.
- Bypass: BYPASS=1, ra_addr=4, w0 r4=0x5A in the same cycle -> ra_data = 0x5A before the edge. BYPASS=0 -> old value before the edge, 0x5A after it.
- Scoreboard: rsv r9 -> next cycle ra_busy(r9) = 1, any_busy = 1. Then w1 r9=0x77 together with rsv r9 -> busy stays 1. Then w1 r9 alone -> busy 0, data 0x77.
- ZERO_REG0=1: w0 r0=0xFF, rsv r0 -> ra_data(r0) = 0x00, ra_busy = 0, any_busy = 0, no conflict raised.
